// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, interrupt FSM encoding and the
// default vector addresses for the three external interrupt lines.
package cp0_pkg;

  localparam logic [4:0] CP0_EPC  = 5'h0E;
  localparam logic [4:0] CP0_DIS  = 5'h16;
  localparam logic [4:0] CP0_MASK = 5'h17;
  localparam logic [4:0] CP0_PEND = 5'h18;
  localparam logic [4:0] CP0_INSV = 5'h19;

  localparam logic [31:0] VEC_HI_DEF  = 32'h0000_0000;
  localparam logic [31:0] VEC_MID_DEF = 32'h0000_0600;
  localparam logic [31:0] VEC_LO_DEF  = 32'h0000_0800;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority (2 > 1 > 0) encoder over the masked pending lines, giving
// a one-hot pick and the handler vector for that line.
module irq_prio_enc
  import cp0_pkg::*;
#(
  parameter logic [31:0] VEC_HI  = VEC_HI_DEF,
  parameter logic [31:0] VEC_MID = VEC_MID_DEF,
  parameter logic [31:0] VEC_LO  = VEC_LO_DEF
) (
  input  logic [2:0]  req_i,
  output logic        valid_o,
  output logic [2:0]  onehot_o,
  output logic [31:0] vector_o
);

  always_comb begin
    valid_o  = |req_i;
    onehot_o = 3'b000;
    vector_o = VEC_LO;
    if (req_i[2]) begin
      onehot_o = 3'b100;
      vector_o = VEC_HI;
    end else if (req_i[1]) begin
      onehot_o = 3'b010;
      vector_o = VEC_MID;
    end else if (req_i[0]) begin
      onehot_o = 3'b001;
      vector_o = VEC_LO;
    end
  end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: latches irq edges, takes an interrupt at a safe
// ID-stage point (squash + EPC save + vector redirect), and services ERET/MTC0/MFC0.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VEC_HI  = VEC_HI_DEF,
  parameter logic [31:0] VEC_MID = VEC_MID_DEF,
  parameter logic [31:0] VEC_LO  = VEC_LO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic [31:0] id_pc,
  input  logic        eret_id,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic [31:0] mfc0_data,
  output logic        take_irq,
  output logic        take_eret,
  output logic [31:0] irq_vector,
  output logic [31:0] epc,
  output logic        int_disable,
  output logic [2:0]  int_mask,
  output logic [2:0]  pending,
  output logic [2:0]  in_service
);

  irq_state_e  state_q, state_d;
  logic [2:0]  irq_q;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  insv_q, insv_d;
  logic        dis_q, dis_d;
  logic [31:0] epc_q, epc_d;

  logic [2:0]  rise;
  logic [2:0]  sel_onehot;
  logic        sel_valid;
  logic        eligible;
  logic        safe;
  logic        mtc0_commit;

  assign rise = irq_in & ~irq_q;

  irq_prio_enc #(
    .VEC_HI  (VEC_HI),
    .VEC_MID (VEC_MID),
    .VEC_LO  (VEC_LO)
  ) u_prio_enc (
    .req_i    (pend_q & mask_q),
    .valid_o  (sel_valid),
    .onehot_o (sel_onehot),
    .vector_o (irq_vector)
  );

  assign eligible = sel_valid & ~dis_q;
  // ERET in ID is never a safe point, which keeps take_irq and take_eret exclusive
  assign safe        = id_valid & ~id_stall & ~eret_id;
  assign take_irq    = ~rst & (state_q == ST_WAIT) & safe & eligible;
  assign take_eret   = ~rst & eret_id & id_valid & ~id_stall;
  assign mtc0_commit = mtc0_we & ~id_stall & ~take_irq;

  always_comb begin
    pend_d  = pend_q;
    mask_d  = mask_q;
    insv_d  = insv_q;
    dis_d   = dis_q;
    epc_d   = epc_q;
    state_d = state_q;

    if (mtc0_commit) begin
      case (cp0_addr)
        CP0_EPC:  epc_d  = mtc0_data;
        CP0_DIS:  dis_d  = mtc0_data[0];
        CP0_MASK: mask_d = mtc0_data[2:0];
        CP0_PEND: pend_d = pend_q & ~mtc0_data[2:0];
        default:  ;
      endcase
    end

    case (state_q)
      ST_IDLE:    if (eligible) state_d = ST_WAIT;
      ST_WAIT:    if (take_irq) state_d = ST_SERVICE;
                  else if (!eligible) state_d = ST_IDLE;
      ST_SERVICE: if (take_eret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Entry and return updates are applied last so they win over a same-edge MTC0
    if (take_irq) begin
      epc_d  = id_pc;
      dis_d  = 1'b1;
      pend_d = pend_d & ~sel_onehot;
      insv_d = sel_onehot;
    end
    if (take_eret) begin
      dis_d = 1'b0;
      if (state_q == ST_SERVICE) insv_d = 3'b000;
    end

    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 3'b000;
      pend_q  <= 3'b000;
      mask_q  <= 3'b111;
      insv_q  <= 3'b000;
      dis_q   <= 1'b0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_in;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insv_q  <= insv_d;
      dis_q   <= dis_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    mfc0_data = 32'h0;
    case (cp0_addr)
      CP0_EPC:  mfc0_data = epc_q;
      CP0_DIS:  mfc0_data = {31'h0, dis_q};
      CP0_MASK: mfc0_data = {29'h0, mask_q};
      CP0_PEND: mfc0_data = {29'h0, pend_q};
      CP0_INSV: mfc0_data = {29'h0, insv_q};
      default:  mfc0_data = 32'h0;
    endcase
  end

  assign epc         = epc_q;
  assign int_disable = dis_q;
  assign int_mask    = mask_q;
  assign pending     = pend_q;
  assign in_service  = insv_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Self-checking bench for cp0_irq_ctrl: a directed vector table, a few
// multi-cycle corner sequences and a randomized run against a reference model.
module tb_cp0_irq_ctrl;

  localparam logic [31:0] VH = 32'h0000_0000;
  localparam logic [31:0] VM = 32'h0000_0600;
  localparam logic [31:0] VL = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic        id_valid = 1'b0;
  logic        id_stall = 1'b0;
  logic [31:0] id_pc = '0;
  logic        eret_id = 1'b0;
  logic        mtc0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic [31:0] mfc0_data, irq_vector, epc;
  logic        take_irq, take_eret, int_disable;
  logic [2:0]  int_mask, pending, in_service;

  int total = 0;
  int bad = 0;

  cp0_irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .id_valid(id_valid), .id_stall(id_stall),
    .id_pc(id_pc), .eret_id(eret_id), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .mtc0_data(mtc0_data), .mfc0_data(mfc0_data), .take_irq(take_irq),
    .take_eret(take_eret), .irq_vector(irq_vector), .epc(epc),
    .int_disable(int_disable), .int_mask(int_mask), .pending(pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic [2:0]  irq;
    logic        valid, stall, eret;
    logic [31:0] pc;
    logic        expIrq, expEret;
    logic [31:0] expVec, expEpc;
    logic        expDis;
    logic [2:0]  expMask, expPend, expInsv;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t row(logic r, logic [2:0] i, logic v, logic s, logic e,
                               logic [31:0] p, logic ti, logic te, logic [31:0] vec,
                               logic [31:0] ep, logic d, logic [2:0] m,
                               logic [2:0] pd, logic [2:0] is);
    vec_t x;
    x.rst = r; x.irq = i; x.valid = v; x.stall = s; x.eret = e; x.pc = p;
    x.expIrq = ti; x.expEret = te; x.expVec = vec; x.expEpc = ep;
    x.expDis = d; x.expMask = m; x.expPend = pd; x.expInsv = is;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    irq_in = '0; id_valid = 1'b0; id_stall = 1'b0; id_pc = '0; eret_id = 1'b0;
    mtc0_we = 1'b0; cp0_addr = '0; mtc0_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; irq_in = v.irq; id_valid = v.valid; id_stall = v.stall;
    eret_id = v.eret; id_pc = v.pc; mtc0_we = 1'b0; cp0_addr = '0; mtc0_data = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitTake(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = take_irq;
    end
    checkOutput(name, {31'h0, seen}, 32'h1);
  endtask

  // Reference model state, described by the controller's architectural rules
  logic [2:0]  mIrqQ, mPend, mMask, mInsv;
  logic        mDis;
  logic [31:0] mEpc;
  int          mMode;

  task automatic modelReset();
    mIrqQ = '0; mPend = '0; mMask = 3'b111; mInsv = '0; mDis = 1'b0; mEpc = '0; mMode = 0;
  endtask

  task automatic modelCheckAndStep();
    int sel = -1;
    bit elig, take, eret, commit;
    logic [31:0] vec, rd;
    logic [2:0] nPend, nMask, nInsv;
    logic nDis;
    logic [31:0] nEpc;
    int nMode;
    for (int i = 2; i >= 0; i--)
      if (sel < 0 && mPend[i] && mMask[i]) sel = i;
    elig = (sel >= 0) && !mDis;
    take = !rst && mMode == 1 && elig && id_valid && !id_stall && !eret_id;
    eret = !rst && eret_id && id_valid && !id_stall;
    vec  = (sel == 2) ? VH : (sel == 1) ? VM : VL;
    case (cp0_addr)
      5'h0E:   rd = mEpc;
      5'h16:   rd = {31'h0, mDis};
      5'h17:   rd = {29'h0, mMask};
      5'h18:   rd = {29'h0, mPend};
      5'h19:   rd = {29'h0, mInsv};
      default: rd = 32'h0;
    endcase
    checkOutput("rndTakeIrq", {31'h0, take_irq}, {31'h0, take});
    checkOutput("rndTakeEret", {31'h0, take_eret}, {31'h0, eret});
    if (take) checkOutput("rndVector", irq_vector, vec);
    checkOutput("rndMfc0", mfc0_data, rd);
    checkOutput("rndEpc", epc, mEpc);
    checkOutput("rndDis", {31'h0, int_disable}, {31'h0, mDis});
    checkOutput("rndMask", {29'h0, int_mask}, {29'h0, mMask});
    checkOutput("rndPend", {29'h0, pending}, {29'h0, mPend});
    checkOutput("rndInsv", {29'h0, in_service}, {29'h0, mInsv});

    if (rst) begin
      modelReset();
      return;
    end
    commit = mtc0_we && !id_stall && !take;
    nPend = mPend; nMask = mMask; nInsv = mInsv; nDis = mDis; nEpc = mEpc; nMode = mMode;
    if (commit) begin
      case (cp0_addr)
        5'h0E:   nEpc = mtc0_data;
        5'h16:   nDis = mtc0_data[0];
        5'h17:   nMask = mtc0_data[2:0];
        5'h18:   nPend = mPend & ~mtc0_data[2:0];
        default: ;
      endcase
    end
    if (take) begin
      nEpc = id_pc; nDis = 1'b1; nPend[sel[1:0]] = 1'b0;
      nInsv = '0; nInsv[sel[1:0]] = 1'b1; nMode = 2;
    end else if (mMode == 1 && !elig) nMode = 0;
    else if (mMode == 0 && elig) nMode = 1;
    if (eret) begin
      nDis = 1'b0;
      if (mMode == 2) begin nInsv = '0; nMode = 0; end
    end
    for (int i = 0; i < 3; i++)
      if (irq_in[i] && !mIrqQ[i]) nPend[i] = 1'b1;
    mPend = nPend; mMask = nMask; mInsv = nInsv; mDis = nDis; mEpc = nEpc; mMode = nMode;
    mIrqQ = irq_in;
  endtask

  logic [4:0] addrs[6] = '{5'h0E, 5'h16, 5'h17, 5'h18, 5'h19, 5'h03};

  initial begin
    // rst irq   v s e  pc        | tIrq tEret vec  epc       dis mask  pend    insv
    tbl[0]  = row(1, 3'b000, 0,0,0, 32'h000, 0,0, VH, 32'h000, 0, 3'h7, 3'b000, 3'b000);
    tbl[1]  = row(1, 3'b000, 1,0,1, 32'h000, 0,0, VH, 32'h000, 0, 3'h7, 3'b000, 3'b000);
    tbl[2]  = row(0, 3'b010, 1,0,0, 32'h100, 0,0, VH, 32'h000, 0, 3'h7, 3'b000, 3'b000);
    tbl[3]  = row(0, 3'b000, 1,0,0, 32'h100, 0,0, VH, 32'h000, 0, 3'h7, 3'b010, 3'b000);
    tbl[4]  = row(0, 3'b000, 1,0,0, 32'h100, 1,0, VM, 32'h000, 0, 3'h7, 3'b010, 3'b000);
    tbl[5]  = row(0, 3'b000, 1,0,0, 32'h104, 0,0, VH, 32'h100, 1, 3'h7, 3'b000, 3'b010);
    tbl[6]  = row(0, 3'b101, 1,0,0, 32'h108, 0,0, VH, 32'h100, 1, 3'h7, 3'b000, 3'b010);
    tbl[7]  = row(0, 3'b000, 1,0,1, 32'h040, 0,1, VH, 32'h100, 1, 3'h7, 3'b101, 3'b010);
    tbl[8]  = row(0, 3'b000, 1,0,0, 32'h200, 0,0, VH, 32'h100, 0, 3'h7, 3'b101, 3'b000);
    tbl[9]  = row(0, 3'b000, 1,0,0, 32'h200, 1,0, VH, 32'h100, 0, 3'h7, 3'b101, 3'b000);
    tbl[10] = row(0, 3'b000, 1,0,0, 32'h204, 0,0, VH, 32'h200, 1, 3'h7, 3'b001, 3'b100);
    tbl[11] = row(0, 3'b000, 1,0,1, 32'h040, 0,1, VH, 32'h200, 1, 3'h7, 3'b001, 3'b100);
    tbl[12] = row(0, 3'b000, 1,0,0, 32'h300, 0,0, VH, 32'h200, 0, 3'h7, 3'b001, 3'b000);
    tbl[13] = row(0, 3'b000, 1,0,0, 32'h300, 1,0, VL, 32'h200, 0, 3'h7, 3'b001, 3'b000);
    tbl[14] = row(0, 3'b000, 1,0,0, 32'h304, 0,0, VH, 32'h300, 1, 3'h7, 3'b000, 3'b001);

    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      applyStimulus(tbl[r]);
      #1;
      checkOutput($sformatf("row%0d.takeIrq", r), {31'h0, take_irq}, {31'h0, tbl[r].expIrq});
      checkOutput($sformatf("row%0d.takeEret", r), {31'h0, take_eret}, {31'h0, tbl[r].expEret});
      if (tbl[r].expIrq) checkOutput($sformatf("row%0d.vector", r), irq_vector, tbl[r].expVec);
      checkOutput($sformatf("row%0d.epc", r), epc, tbl[r].expEpc);
      checkOutput($sformatf("row%0d.dis", r), {31'h0, int_disable}, {31'h0, tbl[r].expDis});
      checkOutput($sformatf("row%0d.mask", r), {29'h0, int_mask}, {29'h0, tbl[r].expMask});
      checkOutput($sformatf("row%0d.pend", r), {29'h0, pending}, {29'h0, tbl[r].expPend});
      checkOutput($sformatf("row%0d.insv", r), {29'h0, in_service}, {29'h0, tbl[r].expInsv});
    end

    // Masked line stays pending without a take until the mask re-enables it
    doReset();
    @(negedge clk); id_valid = 1; id_pc = 32'h400; mtc0_we = 1; cp0_addr = 5'h17; mtc0_data = 0;
    @(negedge clk); mtc0_we = 0; irq_in = 3'b010; #1;
    checkOutput("maskWritten", {29'h0, int_mask}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); irq_in = 0; #1;
      checkOutput("maskedPend", {29'h0, pending}, 32'h2);
      checkOutput("maskedNoTake", {31'h0, take_irq}, 32'h0);
    end
    @(negedge clk); mtc0_we = 1; cp0_addr = 5'h17; mtc0_data = 32'h2; #1;
    checkOutput("maskWrNoTake", {31'h0, take_irq}, 32'h0);
    @(negedge clk); mtc0_we = 0; #1;
    checkOutput("unmaskIdle", {31'h0, take_irq}, 32'h0);
    waitTake("unmaskTake");
    checkOutput("unmaskVector", irq_vector, VM);

    // Stall holds off the take; MTC0 in the take cycle is squashed
    doReset();
    @(negedge clk); id_valid = 1; id_stall = 1; id_pc = 32'h500; irq_in = 3'b001; #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); irq_in = 0; #1;
      checkOutput("stallNoTake", {31'h0, take_irq}, 32'h0);
    end
    @(negedge clk); id_stall = 0; id_pc = 32'h520; mtc0_we = 1; cp0_addr = 5'h17; mtc0_data = 0; #1;
    checkOutput("unstallTake", {31'h0, take_irq}, 32'h1);
    checkOutput("unstallVector", irq_vector, VL);
    @(negedge clk); mtc0_we = 0; cp0_addr = 5'h0E; #1;
    checkOutput("stallEpc", epc, 32'h520);
    checkOutput("stallDis", {31'h0, int_disable}, 32'h1);
    checkOutput("squashedMtc0", {29'h0, int_mask}, 32'h7);
    checkOutput("stallInsv", {29'h0, in_service}, 32'h1);
    checkOutput("mfc0Epc", mfc0_data, 32'h520);
    cp0_addr = 5'h19; #1;
    checkOutput("mfc0Insv", mfc0_data, 32'h1);
    cp0_addr = 5'h03; #1;
    checkOutput("mfc0Unmapped", mfc0_data, 32'h0);

    // Reset during SERVICE with a queued request drops everything
    doReset();
    @(negedge clk); id_valid = 1; id_pc = 32'h600; irq_in = 3'b100; #1;
    @(negedge clk); irq_in = 0; #1;
    @(negedge clk); #1;
    checkOutput("rstSeqTake", {31'h0, take_irq}, 32'h1);
    @(negedge clk); irq_in = 3'b001; #1;
    @(negedge clk); #1;
    checkOutput("svcPend", {29'h0, pending}, 32'h1);
    checkOutput("svcInsv", {29'h0, in_service}, 32'h4);
    @(negedge clk); rst = 1; eret_id = 1; irq_in = 0; #1;
    checkOutput("rstNoEret", {31'h0, take_eret}, 32'h0);
    checkOutput("rstNoIrq", {31'h0, take_irq}, 32'h0);
    @(negedge clk); rst = 0; eret_id = 0; #1;
    checkOutput("rstEpc", epc, 32'h0);
    checkOutput("rstDis", {31'h0, int_disable}, 32'h0);
    checkOutput("rstMask", {29'h0, int_mask}, 32'h7);
    checkOutput("rstPend", {29'h0, pending}, 32'h0);
    checkOutput("rstInsv", {29'h0, in_service}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checkOutput("postRstNoTake", {31'h0, take_irq}, 32'h0);
    end

    // Randomized run against the reference model
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) irq_in = 3'($urandom);
      id_valid  = ($urandom_range(0, 9) != 0);
      id_stall  = ($urandom_range(0, 4) == 0);
      id_pc     = $urandom;
      eret_id   = ($urandom_range(0, 19) == 0);
      mtc0_we   = ($urandom_range(0, 11) == 0);
      cp0_addr  = addrs[$urandom_range(0, 5)];
      mtc0_data = $urandom;
      #1;
      modelCheckAndStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Coprocessor-0 interrupt controller for the 5-stage MIPS pipeline. It latches three external interrupt lines, applies mask, global disable and fixed priority, and picks a safe point at the ID stage to take an interrupt. When it takes one, it squashes the ID instruction, saves its address in EPC and redirects the PC to a per-line vector. It also holds the CP0 registers that MFC0/MTC0 access, and services ERET.

Parameters:
VEC_HI, 32'h0000_0000, entry address for irq_in[2] (highest priority)
VEC_MID, 32'h0000_0600, entry address for irq_in[1]
VEC_LO, 32'h0000_0800, entry address for irq_in[0] (lowest priority)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
irq_in  in  3  device interrupt lines, synchronous to clk; rising edge requests
id_valid  in  1  ID holds a real (non-bubble) instruction
id_stall  in  1  ID paused this cycle (load-use)
id_pc  in  32  address of the instruction currently in ID
eret_id  in  1  ERET decoded in ID
mtc0_we  in  1  MTC0 in ID
cp0_addr  in  5  rd field of MFC0/MTC0 in ID
mtc0_data  in  32  forwarded rt value
mfc0_data  out  32  combinational CP0 read of cp0_addr
take_irq  out  1  combinational; redirect PC to irq_vector and flush ID at this edge
take_eret  out  1  combinational; redirect PC to epc and flush ID at this edge
irq_vector  out  32  vector of the selected line, valid when take_irq=1
epc  out  32  saved resume address
int_disable  out  1  global disable
int_mask  out  3  per-line enable
pending  out  3  latched requests
in_service  out  3  one-hot line being serviced

Behaviour:
- Reset (edge with rst=1):
  - epc=0, int_disable=0, int_mask=3'b111, pending=0, in_service=0, irq_q=0, state=IDLE.
  - take_irq and take_eret are 0 during reset.
- Edge detect, registered:
  - irq_q <= irq_in every cycle.
  - pending[i] <= 1 when irq_in[i] & ~irq_q[i].
  - If a set and a clear of the same bit happen in the same cycle, the set wins.
- Eligibility: eligible = |(pending & int_mask) & ~int_disable.
- Selection: priority is 2 > 1 > 0 over (pending & int_mask), evaluated in the take cycle.
- Safe point: safe = id_valid & ~id_stall & ~eret_id.
- FSM states IDLE, WAIT, SERVICE:
  - IDLE -> WAIT when eligible.
  - WAIT -> IDLE when eligible drops (mask cleared, disable set).
  - WAIT: take_irq = safe & eligible. On that edge:
    - epc <= id_pc; the ID instruction is squashed and re-executed on return.
    - int_disable <= 1; pending[sel] <= 0; in_service <= onehot(sel).
    - state <= SERVICE.
  - SERVICE: take_eret = eret_id & id_valid & ~id_stall. On that edge: int_disable <= 0, in_service <= 0, state <= IDLE.
  - IDLE/WAIT: eret_id also produces take_eret (return from a software-entered handler) and clears int_disable; in_service is unchanged.
- take_irq and take_eret are never both 1. take_irq has priority over a branch/jump redirect in ID in the same cycle.
- CP0 map: 0x0E EPC (RW), 0x16 disable (RW, bit0), 0x17 mask (RW, bits2:0), 0x18 pending (read; write-1-to-clear), 0x19 in_service (RO). Other addresses read 0; writes to them are ignored.
- MTC0 commits at the edge when mtc0_we & ~id_stall.
  - MTC0 is ignored in a take_irq cycle, because the instruction is squashed.
  - An entry or ERET update of disable/EPC overrides an MTC0 to the same register in the same edge.
- Latency: irq edge sampled at edge N -> pending at N -> WAIT after N+1 -> take_irq earliest in cycle N+1..N+2 if safe. Minimum 1 cycle from pending to take.
- Nesting: not supported. Edges during SERVICE accumulate in pending and are taken after ERET.
- Reset mid-operation (any state) returns to the reset values above; pending requests are lost.

Decomposition:
- Shared package cp0_pkg: CP0 address constants (EPC=5'h0E, DIS=5'h16, MASK=5'h17, PEND=5'h18, INSV=5'h19), FSM state encoding, default vector constants.
- One sub-module irq_prio_enc: 3-bit masked priority encoder giving valid, a one-hot output and a vector mux.

Test Plan:
- Reset, then pulse irq_in=3'b010 with ID valid/unstalled and id_pc=0x100 -> take_irq within 2 cycles; irq_vector=0x600, epc=0x100, int_disable=1, pending=0, in_service=3'b010.
- irq_in rising 3'b101 in the same cycle -> line 2 taken first (vector 0x0). After ERET at id_pc=0x40 -> take_eret=1, then line 0 taken (vector 0x800); epc = id_pc of the second take.
- int_mask written 3'b000 via MTC0 addr 0x17, then irq_in[1] pulses -> pending=3'b010, no take_irq. Write mask 3'b010 -> take_irq follows.
- Pending irq with id_stall=1 held for 3 cycles -> take_irq=0 throughout. It asserts the first cycle id_stall=0; epc=id_pc of that cycle.
- MTC0 to 0x16 with data 1 in the same cycle as a take_irq -> MTC0 ignored; int_disable=1 from entry. MFC0 0x0E returns the new epc next cycle.
- Assert rst while in SERVICE with pending=3'b001 -> all outputs at reset values; state IDLE; no take_irq afterward without a new edge.
